btn_event_queue: RTL and testbench
==================================

BTN_EVENT_QUEUE -- requirements
Module: btn_event_queue

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1250000, meaning the stable-input cycles required before a level change is accepted (10 ms at 125 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued press events, power of two.
REQ-003 SHALL have port clk  input  1  system clock, 125 MHz.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports btn1in, btn2in, btn3in  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 SHALL have port evt_valid  output  1  head-of-queue event present.
REQ-007 SHALL have port evt_id  output  2  head event button number: 1, 2 or 3; 0 when evt_valid low.
REQ-008 SHALL have port evt_ready  input  1  consumer (game logic) accepts head event.
REQ-009 SHALL have port btn_lvl  output  3  debounced level per button, bit0 = btn1.
REQ-010 SHALL have port ovf  output  1  sticky flag: a press was lost.
REQ-011 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-012 SHALL pass each btnNin through a 2-flop synchronizer before any other logic.
REQ-013 SHALL keep per button a counter that clears whenever the synced input equals btn_lvl, and otherwise increments.
REQ-014 SHALL toggle btn_lvl[n] and clear the counter in the cycle the counter reaches DEBOUNCE_CYCLES-1 with input still differing; glitches shorter than DEBOUNCE_CYCLES produce no change.
REQ-015 SHALL flag a press on a btn_lvl 0->1 transition only; releases generate no event.
REQ-016 SHALL set pending[n] in the cycle after a press is flagged.
REQ-017 SHALL, each cycle the FIFO is not full or is being popped, push the lowest-index set pending bit and clear it; at most one push per cycle.
REQ-018 SHALL, if a press is flagged while pending[n] is already set, drop it and set ovf.
REQ-019 SHALL present evt_valid = FIFO not empty and evt_id = FIFO head combinationally (show-ahead); evt_valid rises the cycle after the push.
REQ-020 SHALL pop on evt_valid && evt_ready; evt_ready while empty has no effect.
REQ-021 SHALL allow simultaneous push and pop at full; occupancy stays FIFO_DEPTH.
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH with a count of width log2(FIFO_DEPTH)+1.
REQ-023 SHALL give ovf_clr priority lower than a same-cycle ovf set (set wins).
REQ-024 SHALL have latency from raw rising edge to evt_valid of 2 + DEBOUNCE_CYCLES + 2 cycles, with FIFO empty and no pending bits set.

Reset
REQ-025 SHALL, on rst high, asynchronously clear synchronizers, counters, btn_lvl, pending, FIFO pointers and count, and ovf; evt_valid=0, evt_id=0.
REQ-026 SHALL discard all queued and pending events on reset mid-operation; a button held through reset release is reported as a press after debounce.

Structure
REQ-027 SHALL place evt_id codes (EVT_NONE=0, EVT_BTN1..3=1..3) and DEBOUNCE_CYCLES default in the shared game package.
REQ-028 SHALL implement the synchronizer, counter and edge flag as sub-module btn_debounce, instantiated three times.

Verification (bench uses DEBOUNCE_CYCLES=8)
REQ-029 SHALL cover: btn1in high 20 cycles, evt_ready=1 -> single evt_id=1 pulse of evt_valid 12 cycles after the edge.
REQ-030 SHALL cover: btn2in high 5 cycles (glitch) -> no event, btn_lvl stays 0.
REQ-031 SHALL cover: btn1..3 rise same cycle, evt_ready=1 -> events 1,2,3 in consecutive cycles.
REQ-032 SHALL cover: evt_ready=0, five separate btn3 presses -> 4 queued events, 5th press stays pending (no ovf); a 6th press sets ovf; draining yields four evt_id=3, then the pending one.
REQ-033 SHALL cover: rst pulsed with 2 events queued -> evt_valid=0 immediately, nothing delivered afterward.
REQ-034 SHALL cover: ovf_clr asserted in the same cycle as a drop -> ovf remains 1.

Source files
------------

// File: rtl/btn_event_queue_pkg.sv
// Shared definitions for the push-button event queue.
package btn_event_queue_pkg;

    // Default debounce window: 10 ms at 125 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1250000;
    localparam int unsigned NUM_BTN             = 3;

    // Event codes presented on evt_id.
    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_BTN1 = 2'd1,
        EVT_BTN2 = 2'd2,
        EVT_BTN3 = 2'd3
    } evt_id_e;

    // Map a zero-based button index to its event code.
    function automatic evt_id_e btn_evt(input logic [1:0] idx);
        return evt_id_e'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/btn_event_queue_if.sv
// Event handshake between the button queue (master) and game logic (slave).
interface btn_event_queue_if;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/btn_debounce.sv
// Synchronizer, debounce counter and press-edge flag for one button.
module btn_debounce
    import btn_event_queue_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Two-flop sync, then count stable-differing cycles; flag 0->1 toggles only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                lvl   <= ~lvl;
                press <= ~lvl;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_event_queue.sv
// Debounces three buttons and queues their press events for the game logic.
module btn_event_queue
    import btn_event_queue_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn1in,
    input  logic                   btn2in,
    input  logic                   btn3in,
    btn_event_queue_if.master      evt,
    output logic [NUM_BTN-1:0]     btn_lvl,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] pending;

    evt_id_e            mem [FIFO_DEPTH];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      count;

    logic               full_c;
    logic               pop_c;
    logic               push_c;
    evt_id_e            push_id_c;
    logic [NUM_BTN-1:0] push_mask_c;

    assign raw_vec = {btn3in, btn2in, btn1in};

    // One debouncer per button.
    for (genvar n = 0; n < NUM_BTN; n++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_vec[n]),
            .lvl   (btn_lvl[n]),
            .press (press[n])
        );
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_c        = (count == CW'(FIFO_DEPTH));
    assign evt.evt_valid = (count != '0);
    assign evt.evt_id    = evt.evt_valid ? mem[rptr] : EVT_NONE;
    assign pop_c         = evt.evt_valid && evt.evt_ready;

    // Pick the lowest-index pending button whenever a slot is (or becomes) free.
    always_comb begin
        push_c      = 1'b0;
        push_id_c   = EVT_NONE;
        push_mask_c = '0;
        if (!full_c || pop_c) begin
            for (int n = NUM_BTN - 1; n >= 0; n--) begin
                if (pending[n]) begin
                    push_c      = 1'b1;
                    push_id_c   = btn_evt(2'(n));
                    push_mask_c = NUM_BTN'(1) << n;
                end
            end
        end
    end

    // Pending bits, FIFO pointers/occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= (pending & ~push_mask_c) | (press & ~pending);
            if (push_c) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop_c) begin
                rptr <= ptr_inc(rptr);
            end
            count <= count + CW'(push_c) - CW'(pop_c);
            if (|(press & pending)) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wptr] <= push_id_c;
        end
    end

endmodule

// File: tb/tb_btn_event_queue.sv
// Scoreboard bench for btn_event_queue with a short debounce window.
module tb_btn_event_queue;
    import btn_event_queue_pkg::*;

    localparam int unsigned DB = 8;
    localparam int LAT = 2 + DB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn1in = 1'b0;
    logic       btn2in = 1'b0;
    logic       btn3in = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] btn_lvl;
    logic       ovf;

    btn_event_queue_if bus ();

    btn_event_queue #(
        .DEBOUNCE_CYCLES (DB),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn1in  (btn1in),
        .btn2in  (btn2in),
        .btn3in  (btn3in),
        .evt     (bus),
        .btn_lvl (btn_lvl),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q [$];
    logic [1:0] obs_q [$];
    int         obs_t [$];

    // Record every accepted event with the cycle it was seen.
    always @(negedge clk) begin
        if (bus.evt_valid && bus.evt_ready) begin
            obs_q.push_back(bus.evt_id);
            obs_t.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [2:0] v);
        {btn3in, btn2in, btn1in} = v;
    endtask

    task automatic press(input logic [2:0] v, input int hi, input int lo);
        set_btn(v);
        step(hi);
        set_btn(3'b000);
        step(lo);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic test_reset();
        bus.evt_ready = 1'b0;
        step(3);
        checks++;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.evt_valid); end
        checks++;
        if (bus.evt_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.evt_id); end
        checks++;
        if (btn_lvl !== 3'b000) begin errors++; $display("FAIL reset_lvl: got %b want 000", btn_lvl); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst = 1'b0;
        step(2);
        checks++;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_single_press();
        int c0;
        clear_sb();
        bus.evt_ready = 1'b1;
        c0 = cyc;
        set_btn(3'b001);
        exp_q.push_back(2'd1);
        step(20);
        checks++;
        if (btn_lvl !== 3'b001) begin errors++; $display("FAIL single_lvl_high: got %b want 001", btn_lvl); end
        set_btn(3'b000);
        step(20);
        checks++;
        if (btn_lvl !== 3'b000) begin errors++; $display("FAIL single_lvl_low: got %b want 000", btn_lvl); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_id: got %0d want %0d", obs_q[0], exp_q[0]); end
            checks++;
            if (obs_t[0] != c0 + LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", obs_t[0] - c0, LAT); end
        end
    endtask

    task automatic test_glitch();
        int bad;
        clear_sb();
        bus.evt_ready = 1'b1;
        bad = 0;
        set_btn(3'b010);
        step(5);
        set_btn(3'b000);
        for (int i = 0; i < 20; i++) begin
            if (btn_lvl !== 3'b000) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL glitch_lvl: %0d cycles with btn_lvl set, want 0", bad); end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d events want 0", obs_q.size()); end
    endtask

    task automatic test_simultaneous();
        int c0;
        clear_sb();
        bus.evt_ready = 1'b1;
        c0 = cyc;
        set_btn(3'b111);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        step(20);
        set_btn(3'b000);
        step(20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL simul_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL simul_id[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
                checks++;
                if (obs_t[i] != c0 + LAT + i) begin errors++; $display("FAIL simul_time[%0d]: got %0d want %0d", i, obs_t[i] - c0, LAT + i); end
            end
        end
    endtask

    task automatic test_overflow();
        clear_sb();
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            press(3'b100, 14, 14);
            exp_q.push_back(2'd3);
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_after_5: got %b want 0", ovf); end
        checks++;
        if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd3) begin
            errors++; $display("FAIL head_after_5: got valid=%b id=%0d want valid=1 id=3", bus.evt_valid, bus.evt_id);
        end
        press(3'b100, 14, 14);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_after_6: got %b want 1", ovf); end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        bus.evt_ready = 1'b1;
        step(12);
        bus.evt_ready = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL drain_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL drain_id[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got valid=%b want 0", bus.evt_valid); end
    endtask

    task automatic test_ovf_clr_collision();
        clear_sb();
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            press(3'b010, 14, 14);
            exp_q.push_back(2'd2);
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL coll_pre_ovf: got %b want 0", ovf); end
        // Drop lands on the edge 2+DB+1 after the raw rise.
        set_btn(3'b010);
        step(2 + DB);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL coll_ovf: got %b want 1", ovf); end
        step(1);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL coll_ovf_hold: got %b want 1", ovf); end
        step(2);
        set_btn(3'b000);
        step(14);
        bus.evt_ready = 1'b1;
        step(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL coll_drain_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL coll_drain_id[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
            end
        end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_sb();
        bus.evt_ready = 1'b0;
        press(3'b001, 14, 14);
        press(3'b001, 14, 14);
        checks++;
        if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", bus.evt_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.evt_valid !== 1'b0 || bus.evt_id !== 2'd0) begin
            errors++; $display("FAIL mid_async_clear: got valid=%b id=%0d want 0/0", bus.evt_valid, bus.evt_id);
        end
        step(2);
        rst = 1'b0;
        bus.evt_ready = 1'b1;
        step(30);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL mid_after_reset: got %0d events want 0", obs_q.size()); end

        // Button held across reset release reports as a fresh press.
        clear_sb();
        set_btn(3'b100);
        step(2);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        c0 = cyc;
        exp_q.push_back(2'd3);
        step(20);
        set_btn(3'b000);
        step(16);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL held_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL held_id: got %0d want %0d", obs_q[0], exp_q[0]); end
            checks++;
            if (obs_t[0] != c0 + LAT) begin errors++; $display("FAIL held_latency: got %0d want %0d", obs_t[0] - c0, LAT); end
        end
    endtask

    initial begin
        bus.evt_ready = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_overflow();
        test_ovf_clr_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
